// File: rtl/pc_seq_pkg.sv
// Shared state encoding, vector defaults and word-offset helper for the pc sequencer.
// TRAP exists only when PCSEQ_EXC_EN is defined.
package pc_seq_pkg;

`ifdef PCSEQ_EXC_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;
`endif

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_0180;
    localparam int unsigned WORD_SHIFT      = 2;

    // Branch offsets arrive in words; the pc counts bytes.
    function automatic logic [31:0] word_offset(input logic [31:0] simm);
        return simm << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-pc selection: pc+4, branch target, jump target; jump beats branch. Latency: combinational.
// Backpressure: none, pure function of its inputs.
module next_pc_calc
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] signimm,
    input  logic        jump,
    input  logic [25:0] jump_addr26,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] branch_target;

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + word_offset(signimm);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_addr26, 2'b00};
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: one outstanding imem fetch, result held until the core consumes it; min 2 cycles/instr.
// Backpressure: instr_ready=0 parks in HOLD with no new fetch. PCSEQ_EXC_EN adds imem_err/epc and the TRAP path.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR
`ifdef PCSEQ_EXC_EN
    ,
    parameter logic [31:0] EXC_VECTOR   = PC_EXC_VECTOR
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] signimm,
    input  logic        jump,
    input  logic [25:0] jump_addr26,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
`ifdef PCSEQ_EXC_EN
    ,
    input  logic        imem_err,
    output logic [31:0] epc
`endif
);

    state_t      state;
    state_t      state_nxt;
    logic        fetch_done;
    logic        consume;
    logic        trap_take;
    logic [31:0] next_pc;

    next_pc_calc u_next_pc (
        .pc           (pc),
        .branch_taken (branch_taken),
        .signimm      (signimm),
        .jump         (jump),
        .jump_addr26  (jump_addr26),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // imem_req is decoded from state so reset drops it without a clock edge.
    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        fetch_done = 1'b0;
        consume    = 1'b0;
        trap_take  = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
`ifdef PCSEQ_EXC_EN
                    if (imem_err) begin
                        trap_take = 1'b1;
                        state_nxt = TRAP;
                    end else begin
                        fetch_done = 1'b1;
                        state_nxt  = HOLD;
                    end
`else
                    fetch_done = 1'b1;
                    state_nxt  = HOLD;
`endif
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    consume   = 1'b1;
                    state_nxt = FETCH;
                end
            end
`ifdef PCSEQ_EXC_EN
            TRAP: state_nxt = FETCH;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_VECTOR;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            retired     <= 32'd0;
`ifdef PCSEQ_EXC_EN
            epc         <= 32'd0;
`endif
        end else begin
            if (fetch_done) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (consume) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
                retired     <= retired + 32'd1;
            end
`ifdef PCSEQ_EXC_EN
            if (trap_take) begin
                epc <= pc;
            end
            if (state == TRAP) begin
                pc <= EXC_VECTOR;
            end
`endif
        end
    end

`ifndef PCSEQ_EXC_EN
    // trap_take only has a consumer in the exception build.
    logic unused_trap;
    assign unused_trap = trap_take;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized run against a transaction-level model.
// Build with PCSEQ_EXC_EN defined to also exercise the fetch-error trap.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] signimm;
    logic        jump;
    logic [25:0] jump_addr26;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;
`ifdef PCSEQ_EXC_EN
    logic        imem_err;
    logic [31:0] epc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: address the sequencer should be fetching/holding and instructions retired.
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .signimm      (signimm),
        .jump         (jump),
        .jump_addr26  (jump_addr26),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .retired      (retired)
`ifdef PCSEQ_EXC_EN
        ,
        .imem_err     (imem_err),
        .epc          (epc)
`endif
    );

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic j, input logic b,
                                             input logic [31:0] s, input logic [25:0] a);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (j) return {seq[31:28], a, 2'b00};
        if (b) return seq + s * 32'd4;
        return seq;
    endfunction

    task automatic clear_inputs();
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        signimm      = 32'd0;
        jump         = 1'b0;
        jump_addr26  = 26'd0;
`ifdef PCSEQ_EXC_EN
        imem_err     = 1'b0;
`endif
    endtask

    // Called at a negedge while fetching: zero-wait ack, then consume with the given control.
    task automatic fetch_consume(input logic [31:0] word, input logic j, input logic b,
                                 input logic [31:0] s, input logic [25:0] a);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack     = 1'b0;
        instr_ready  = 1'b1;
        jump         = j;
        branch_taken = b;
        signimm      = s;
        jump_addr26  = a;
        @(negedge clk);
        clear_inputs();
        m_pc  = ref_next(m_pc, j, b, s, a);
        m_ret = m_ret + 32'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (pc !== RV)           begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
        if (imem_req !== 1'b0)   begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        if (instr !== 32'd0)     begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        if (retired !== 32'd0)   begin n_fail++; $display("FAIL reset_retired: got %h want 0", retired); end
`ifdef PCSEQ_EXC_EN
        n_checks++;
        if (epc !== 32'd0)       begin n_fail++; $display("FAIL reset_epc: got %h want 0", epc); end
`endif
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0)   begin n_fail++; $display("FAIL idle_req: got %b want 0", imem_req); end
        @(negedge clk);
        n_checks += 2;
        if (imem_req !== 1'b1)   begin n_fail++; $display("FAIL first_req: got %b want 1", imem_req); end
        if (imem_addr !== RV)    begin n_fail++; $display("FAIL first_addr: got %h want %h", imem_addr, RV); end
        m_pc  = RV;
        m_ret = 32'd0;
    endtask

    task automatic test_sequential();
        logic [31:0] w;
        for (int i = 0; i < 3; i++) begin
            n_checks += 2;
            if (imem_req !== 1'b1)  begin n_fail++; $display("FAIL seq_req[%0d]: got %b want 1", i, imem_req); end
            if (imem_addr !== RV + 32'(4 * i)) begin
                n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, RV + 32'(4 * i));
            end
            w = $urandom;
            imem_ack   = 1'b1;
            imem_rdata = w;
            @(negedge clk);
            imem_ack = 1'b0;
            n_checks += 3;
            if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, instr_valid); end
            if (instr !== w)          begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr, w); end
            if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL seq_hold_req[%0d]: got %b want 0", i, imem_req); end
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
        end
        m_pc  = RV + 32'd12;
        m_ret = 32'd3;
        n_checks += 2;
        if (retired !== 32'd3)     begin n_fail++; $display("FAIL seq_retired: got %0d want 3", retired); end
        if (instr_valid !== 1'b0)  begin n_fail++; $display("FAIL seq_valid_clr: got %b want 0", instr_valid); end
    endtask

    task automatic test_branch();
        fetch_consume($urandom, 1'b1, 1'b0, 32'd0, 26'h40);
        n_checks++;
        if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL jump_to_100: got %h want 00000100", imem_addr); end
        fetch_consume($urandom, 1'b0, 1'b1, 32'hFFFF_FFFE, 26'h3FF_FFFF);
        n_checks += 2;
        if (imem_addr !== 32'h0FC) begin n_fail++; $display("FAIL branch_back: got %h want 000000fc", imem_addr); end
        if (retired !== m_ret)     begin n_fail++; $display("FAIL branch_retired: got %0d want %0d", retired, m_ret); end
    endtask

    task automatic test_jump_priority();
        fetch_consume($urandom, 1'b1, 1'b0, 32'd0, 26'h10_0000);
        n_checks++;
        if (imem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL jump_to_400000: got %h want 00400000", imem_addr); end
        fetch_consume($urandom, 1'b1, 1'b1, 32'h0000_1234, 26'h10);
        n_checks++;
        if (imem_addr !== 32'h0000_0040) begin n_fail++; $display("FAIL jump_priority: got %h want 00000040", imem_addr); end
    endtask

    task automatic test_wrap();
        logic [31:0] s;
        s = (32'hFFFF_FFFC - (m_pc + 32'd4)) >> 2;
        fetch_consume($urandom, 1'b0, 1'b1, s, 26'd0);
        n_checks += 2;
        if (pc !== 32'hFFFF_FFFC)  begin n_fail++; $display("FAIL wrap_pc: got %h want fffffffc", pc); end
        if (pc_plus4 !== 32'd0)    begin n_fail++; $display("FAIL wrap_plus4: got %h want 00000000", pc_plus4); end
        fetch_consume($urandom, 1'b0, 1'b0, 32'd0, 26'd0);
        n_checks++;
        if (imem_addr !== 32'd0)   begin n_fail++; $display("FAIL wrap_next: got %h want 00000000", imem_addr); end
    endtask

    task automatic test_hold();
        logic [31:0] w;
        w = $urandom;
        imem_ack   = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            // A stray ack while holding must not disturb the held word.
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = ~w;
            @(negedge clk);
            n_checks += 5;
            if (instr !== w)          begin n_fail++; $display("FAIL hold_instr[%0d]: got %h want %h", i, instr, w); end
            if (pc !== m_pc)          begin n_fail++; $display("FAIL hold_pc[%0d]: got %h want %h", i, pc, m_pc); end
            if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, instr_valid); end
            if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL hold_req[%0d]: got %b want 0", i, imem_req); end
            if (retired !== m_ret)    begin n_fail++; $display("FAIL hold_retired[%0d]: got %0d want %0d", i, retired, m_ret); end
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
        m_pc  = m_pc + 32'd4;
        m_ret = m_ret + 32'd1;
        n_checks++;
        if (imem_addr !== m_pc) begin n_fail++; $display("FAIL hold_release: got %h want %h", imem_addr, m_pc); end
    endtask

    task automatic test_reset_inflight();
        n_checks++;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL inflight_req: got %b want 1", imem_req); end
        #2;
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL async_req: got %b want 0", imem_req); end
        if (pc !== RV)            begin n_fail++; $display("FAIL async_pc: got %h want %h", pc, RV); end
        if (retired !== 32'd0)    begin n_fail++; $display("FAIL async_retired: got %0d want 0", retired); end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL late_ack_valid: got %b want 0", instr_valid); end
        if (imem_req !== 1'b1)    begin n_fail++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
        if (imem_addr !== RV)     begin n_fail++; $display("FAIL post_reset_addr: got %h want %h", imem_addr, RV); end
        clear_inputs();
        m_pc  = RV;
        m_ret = 32'd0;
    endtask

    task automatic test_random();
        logic        m_valid;
        logic [31:0] m_instr;
        logic        a, r, j, b;
        logic [31:0] d, s;
        logic [25:0] t;
        m_valid = 1'b0;
        m_instr = 32'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks += 5;
            if (imem_addr !== m_pc)       begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, imem_addr, m_pc); end
            if (pc_plus4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_plus4@%0d: got %h want %h", cyc, pc_plus4, m_pc + 32'd4); end
            if (retired !== m_ret)        begin n_fail++; $display("FAIL rnd_retired@%0d: got %0d want %0d", cyc, retired, m_ret); end
            if (instr_valid !== m_valid)  begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, instr_valid, m_valid); end
            if (imem_req !== !m_valid)    begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, imem_req, !m_valid); end
            if (m_valid) begin
                n_checks++;
                if (instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h want %h", cyc, instr, m_instr); end
            end
            a = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) != 0);
            j = ($urandom_range(0, 3) == 0);
            b = 1'($urandom_range(0, 1));
            d = $urandom;
            s = $urandom;
            t = 26'($urandom);
            imem_ack     = a;
            imem_rdata   = d;
            instr_ready  = r;
            jump         = j;
            branch_taken = b;
            signimm      = s;
            jump_addr26  = t;
            @(negedge clk);
            if (!m_valid && a) begin
                m_valid = 1'b1;
                m_instr = d;
            end else if (m_valid && r) begin
                m_pc    = ref_next(m_pc, j, b, s, t);
                m_valid = 1'b0;
                m_ret   = m_ret + 32'd1;
            end
        end
        // Drain any held word so the bench leaves the DUT fetching.
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        jump        = 1'b0;
        branch_taken = 1'b0;
        if (m_valid) begin
            @(negedge clk);
            m_pc  = m_pc + 32'd4;
            m_ret = m_ret + 32'd1;
        end
        clear_inputs();
        n_checks++;
        if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_drain: got %h want %h", imem_addr, m_pc); end
    endtask

`ifdef PCSEQ_EXC_EN
    task automatic test_exc();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_pc  = RV;
        m_ret = 32'd0;
        fetch_consume($urandom, 1'b1, 1'b0, 32'd0, 26'h80);
        n_checks++;
        if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL exc_setup: got %h want 00000200", imem_addr); end
        imem_ack   = 1'b1;
        imem_err   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        clear_inputs();
        n_checks += 4;
        if (epc !== 32'h200)      begin n_fail++; $display("FAIL exc_epc: got %h want 00000200", epc); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL exc_valid: got %b want 0", instr_valid); end
        if (imem_req !== 1'b0)    begin n_fail++; $display("FAIL exc_trap_req: got %b want 0", imem_req); end
        if (retired !== m_ret)    begin n_fail++; $display("FAIL exc_retired: got %0d want %0d", retired, m_ret); end
        @(negedge clk);
        n_checks += 3;
        if (imem_req !== 1'b1)    begin n_fail++; $display("FAIL exc_refetch_req: got %b want 1", imem_req); end
        if (imem_addr !== EV)     begin n_fail++; $display("FAIL exc_vector: got %h want %h", imem_addr, EV); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL exc_valid_after: got %b want 0", instr_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_wrap();
        test_hold();
        test_reset_inflight();
        test_random();
`ifdef PCSEQ_EXC_EN
        test_exc();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0180, SHALL be the fetch address after a fetch error (PCSEQ_EXC_EN only).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port imem_req, output, 1: fetch request to instruction memory.
REQ-006 Port imem_addr, output, 32: fetch address; always equals pc.
REQ-007 Port imem_ack, input, 1: memory has accepted the request and returned data.
REQ-008 Port imem_rdata, input, 32: instruction word; valid only when imem_ack=1.
REQ-009 Port instr, output, 32: registered instruction presented to the core.
REQ-010 Port instr_valid, output, 1: instr holds an unconsumed instruction.
REQ-011 Port instr_ready, input, 1: core consumes instr this cycle.
REQ-012 Port branch_taken, input, 1: resolved branch outcome; sampled only at consume.
REQ-013 Port signimm, input, 32: sign-extended branch offset in words.
REQ-014 Port jump, input, 1: unconditional jump; sampled only at consume.
REQ-015 Port jump_addr26, input, 26: jump target index field.
REQ-016 Port pc, output, 32: address of the instruction currently fetched or held.
REQ-017 Port pc_plus4, output, 32: pc+4, combinational.
REQ-018 Port retired, output, 32: count of consumed instructions.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, HOLD and, with PCSEQ_EXC_EN defined, TRAP.
REQ-020 IDLE SHALL be the reset state; the first clock edge after rst deasserts SHALL move the FSM to FETCH.
REQ-021 FETCH SHALL assert imem_req and hold imem_addr stable until imem_ack=1.
REQ-022 On FETCH with imem_ack=1, the block SHALL latch imem_rdata into instr, set instr_valid and move to HOLD at that edge.
REQ-023 HOLD SHALL keep instr, pc and instr_valid stable while instr_ready=0.
REQ-024 Consume SHALL be defined as HOLD && instr_ready; at consume the block SHALL load the next pc, clear instr_valid, increment retired and return to FETCH.
REQ-025 The next pc SHALL be {pc_plus4[31:28], jump_addr26, 2'b00} when jump=1.
REQ-026 Otherwise, the next pc SHALL be pc_plus4 + (signimm << 2) in 32-bit modulo arithmetic when branch_taken=1.
REQ-027 Otherwise, the next pc SHALL be pc_plus4.
REQ-028 When jump and branch_taken are both 1, jump SHALL take priority.
REQ-029 pc+4 and the branch target SHALL wrap modulo 2^32: pc=32'hFFFF_FFFC gives pc_plus4=0.
REQ-030 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 imem_ack SHALL be ignored outside FETCH.
REQ-032 Throughput SHALL be at most one instruction per 2 cycles; with a zero-wait ack, instr_valid SHALL rise 1 cycle after the first imem_req.

Reset
REQ-033 While rst=1, independent of clk: pc=RESET_VECTOR, state=IDLE, imem_req=0, instr=0, instr_valid=0, retired=0, epc=0.
REQ-034 An in-flight fetch SHALL be abandoned on reset, and a late imem_ack SHALL be ignored.

Configuration
REQ-035 With PCSEQ_EXC_EN defined, the block SHALL add input imem_err (1 bit) and output epc (32 bits).
REQ-036 With PCSEQ_EXC_EN defined, imem_ack && imem_err in FETCH SHALL load epc with pc, go to TRAP and leave instr_valid=0.
REQ-037 TRAP SHALL set pc to EXC_VECTOR and go to FETCH on the next edge; retired SHALL not increment.
REQ-038 Without PCSEQ_EXC_EN, the imem_err and epc ports, the TRAP state and the EXC_VECTOR usage SHALL be absent.

Structure
REQ-039 Package pc_seq_pkg SHALL hold the state encoding typedef, the default RESET_VECTOR and EXC_VECTOR constants, and the word-shift constant.
REQ-040 Sub-module next_pc_calc SHALL hold the combinational pc+4, branch-target adder and priority mux; pc_sequencer SHALL hold the FSM and registers.

Verification
REQ-041 Reset release, zero-wait ack, instr_ready=1 -> imem_addr sequence 0,4,8; retired=3 after three consumes.
REQ-042 pc=0x100, branch_taken=1, signimm=0xFFFF_FFFE at consume -> next imem_addr=0x0FC.
REQ-043 pc=0x0040_0000, jump=1, branch_taken=1, jump_addr26=0x10 at consume -> next imem_addr=0x0000_0040.
REQ-044 instr_ready held 0 for 5 cycles -> instr, pc and instr_valid unchanged; no imem_req; retired unchanged.
REQ-045 rst pulsed while imem_req=1 with a pending ack -> imem_req drops without waiting for clk; next fetch address=RESET_VECTOR.
REQ-046 With PCSEQ_EXC_EN: pc=0x200, imem_ack=1 with imem_err=1 -> epc=0x200; next imem_addr=0x180; instr_valid never set for 0x200.
